// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - merges ALU and load write-backs into one register-file write port
// Optional feature macro: WB_FORWARD_EN (adds lookup_rs/lookup_hit/lookup_data forwarding search).
module regfile_write_arbiter #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   alu_valid,
  input  logic [4:0]             alu_rd,
  input  logic [XLEN-1:0]        alu_data,
  input  logic                   ld_valid,
  input  logic [4:0]             ld_rd,
  input  logic [XLEN-1:0]        ld_data,
  output logic                   in_ready,
  output logic                   RegWrite,
  output logic [4:0]             RD,
  output logic [XLEN-1:0]        WriteData,
  output logic [$clog2(DEPTH):0] pending
`ifdef WB_FORWARD_EN
  ,
  input  logic [4:0]             lookup_rs,
  output logic                   lookup_hit,
  output logic [XLEN-1:0]        lookup_data
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [4:0]      r_rd_mem   [DEPTH];
  logic [XLEN-1:0] r_data_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_reg_write;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_write_data;

  logic            w_in_ready;
  logic            w_push_ld;
  logic            w_push_alu;
  logic            w_pop;
  logic [PW-1:0]   w_ld_idx;
  logic [PW-1:0]   w_alu_idx;
  logic [CW-1:0]   w_count_next;

  // Two free slots are required so a simultaneous ld+alu pair always fits;
  // the current pop is deliberately not credited so in_ready depends on count only.
  assign w_in_ready = !reset && (r_count <= CW'(DEPTH - 2));

  // Writes to x0 are architecturally dead, so they are dropped at the door.
  assign w_push_ld  = w_in_ready && ld_valid  && (ld_rd  != 5'd0);
  assign w_push_alu = w_in_ready && alu_valid && (alu_rd != 5'd0);
  assign w_pop      = (r_count != '0);

  // The load entry is older than the ALU entry when both arrive together.
  assign w_ld_idx   = r_wr_ptr;
  assign w_alu_idx  = r_wr_ptr + PW'(w_push_ld);

  assign w_count_next = r_count + CW'(w_push_ld) + CW'(w_push_alu) - CW'(w_pop);

  assign in_ready  = w_in_ready;
  assign RegWrite  = r_reg_write;
  assign RD        = r_rd;
  assign WriteData = r_write_data;
  assign pending   = r_count;

  // Queue storage: no reset needed, validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push_ld) begin
      r_rd_mem[w_ld_idx]   <= ld_rd;
      r_data_mem[w_ld_idx] <= ld_data;
    end
    if (w_push_alu) begin
      r_rd_mem[w_alu_idx]   <= alu_rd;
      r_data_mem[w_alu_idx] <= alu_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PW'(w_push_ld) + PW'(w_push_alu);
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_count <= w_count_next;
    end
  end

  // Registered write port: head pops every non-empty cycle; RD/WriteData hold when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_reg_write  <= 1'b0;
      r_rd         <= 5'd0;
      r_write_data <= '0;
    end else begin
      r_reg_write <= w_pop;
      if (w_pop) begin
        r_rd         <= r_rd_mem[r_rd_ptr];
        r_write_data <= r_data_mem[r_rd_ptr];
      end
    end
  end

`ifdef WB_FORWARD_EN
  logic            w_q_hit;
  logic [XLEN-1:0] w_q_data;
  logic [PW-1:0]   w_idx;

  // Scan live entries oldest to youngest so the youngest match wins.
  always_comb begin
    w_q_hit  = 1'b0;
    w_q_data = '0;
    w_idx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_rd_ptr + PW'(i);
      if ((CW'(i) < r_count) && (r_rd_mem[w_idx] == lookup_rs)) begin
        w_q_hit  = 1'b1;
        w_q_data = r_data_mem[w_idx];
      end
    end
  end

  // Queue entries are younger than the write-port register, so they take precedence.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    if (lookup_rs != 5'd0) begin
      if (w_q_hit) begin
        lookup_hit  = 1'b1;
        lookup_data = w_q_data;
      end else if (r_reg_write && (r_rd == lookup_rs)) begin
        lookup_hit  = 1'b1;
        lookup_data = r_write_data;
      end
    end
  end
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - directed self-checking bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

  logic        clk;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [63:0] alu_data;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [63:0] ld_data;
  logic        in_ready;
  logic        RegWrite;
  logic [4:0]  RD;
  logic [63:0] WriteData;
  logic [2:0]  pending;
`ifdef WB_FORWARD_EN
  logic [4:0]  lookup_rs;
  logic        lookup_hit;
  logic [63:0] lookup_data;
`endif

  int n_cmp;
  int n_fail;

  regfile_write_arbiter #(.DEPTH(4), .XLEN(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .ld_valid  (ld_valid),
    .ld_rd     (ld_rd),
    .ld_data   (ld_data),
    .in_ready  (in_ready),
    .RegWrite  (RegWrite),
    .RD        (RD),
    .WriteData (WriteData),
    .pending   (pending)
`ifdef WB_FORWARD_EN
    ,
    .lookup_rs   (lookup_rs),
    .lookup_hit  (lookup_hit),
    .lookup_data (lookup_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs;
    alu_valid = 1'b0; alu_rd = 5'd0; alu_data = '0;
    ld_valid  = 1'b0; ld_rd  = 5'd0; ld_data  = '0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %0b want 0", RegWrite); end
    n_cmp++; if (RD !== 5'd0) begin n_fail++; $display("FAIL rst_rd: got %0d want 0", RD); end
    n_cmp++; if (WriteData !== 64'h0) begin n_fail++; $display("FAIL rst_wd: got %h want 0", WriteData); end
    n_cmp++; if (pending !== 3'd0) begin n_fail++; $display("FAIL rst_pending: got %0d want 0", pending); end
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %0b want 0", in_ready); end
    // release reset and present a request on the very same cycle
    reset = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 64'h99;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rel_ready: got %0b want 1", in_ready); end
    @(negedge clk);
    n_cmp++; if (pending !== 3'd1) begin n_fail++; $display("FAIL rel_pending: got %0d want 1", pending); end
    idle_inputs();
    @(negedge clk);
    n_cmp++; if (RegWrite !== 1'b1 || RD !== 5'd9 || WriteData !== 64'h99) begin
      n_fail++; $display("FAIL rel_write: got we=%0b rd=%0d wd=%h want we=1 rd=9 wd=99", RegWrite, RD, WriteData);
    end
  endtask

  task automatic test_single_push;
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'h1234;
    @(negedge clk);
    idle_inputs();
    n_cmp++; if (pending !== 3'd1 || RegWrite !== 1'b0) begin
      n_fail++; $display("FAIL single_n: got pending=%0d we=%0b want pending=1 we=0", pending, RegWrite);
    end
    @(negedge clk);
    n_cmp++; if (RegWrite !== 1'b1 || RD !== 5'd5 || WriteData !== 64'h1234 || pending !== 3'd0) begin
      n_fail++; $display("FAIL single_n1: got we=%0b rd=%0d wd=%h p=%0d want we=1 rd=5 wd=1234 p=0", RegWrite, RD, WriteData, pending);
    end
    @(negedge clk);
    n_cmp++; if (RegWrite !== 1'b0 || RD !== 5'd5 || WriteData !== 64'h1234) begin
      n_fail++; $display("FAIL single_n2: got we=%0b rd=%0d wd=%h want we=0 rd=5 wd=1234", RegWrite, RD, WriteData);
    end
  endtask

  task automatic test_dual_push;
    ld_valid  = 1'b1; ld_rd  = 5'd3; ld_data  = 64'hA;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 64'hB;
    @(negedge clk);
    idle_inputs();
    n_cmp++; if (pending !== 3'd2) begin n_fail++; $display("FAIL dual_pending: got %0d want 2", pending); end
    @(negedge clk);
    n_cmp++; if (RegWrite !== 1'b1 || RD !== 5'd3 || WriteData !== 64'hA) begin
      n_fail++; $display("FAIL dual_first: got we=%0b rd=%0d wd=%h want we=1 rd=3 wd=a", RegWrite, RD, WriteData);
    end
    @(negedge clk);
    n_cmp++; if (RegWrite !== 1'b1 || RD !== 5'd3 || WriteData !== 64'hB) begin
      n_fail++; $display("FAIL dual_second: got we=%0b rd=%0d wd=%h want we=1 rd=3 wd=b", RegWrite, RD, WriteData);
    end
    @(negedge clk);
    n_cmp++; if (RegWrite !== 1'b0 || pending !== 3'd0) begin
      n_fail++; $display("FAIL dual_idle: got we=%0b p=%0d want we=0 p=0", RegWrite, pending);
    end
  endtask

  task automatic test_x0_filter;
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 64'hFF;
    @(negedge clk);
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (pending !== 3'd0 || RegWrite !== 1'b0) begin
        n_fail++; $display("FAIL x0_cycle%0d: got p=%0d we=%0b want p=0 we=0", i, pending, RegWrite);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    logic [4:0]  q_rd[$];
    logic [63:0] q_data[$];
    logic [4:0]  erd;
    logic [63:0] edata;
    int          mcount;
    int          k;
    int          nout;
    bit          exp_ready;
    bit          exp_we;
    bit          saw_drop;
    mcount = 0; k = 0; nout = 0; saw_drop = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      exp_ready = (mcount <= 2);
      if (k < 4) begin
        ld_valid  = 1'b1; ld_rd  = 5'(10 + 2 * k); ld_data  = 64'h100 + 64'(k);
        alu_valid = 1'b1; alu_rd = 5'(11 + 2 * k); alu_data = 64'h200 + 64'(k);
      end else begin
        idle_inputs();
      end
      #1;
      n_cmp++; if (in_ready !== exp_ready) begin
        n_fail++; $display("FAIL bp_ready_c%0d: got %0b want %0b", cyc, in_ready, exp_ready);
      end
      if (!exp_ready) saw_drop = 1'b1;
      @(negedge clk);
      exp_we = (mcount > 0);
      erd = 5'd0; edata = '0;
      if (exp_we) begin
        erd = q_rd.pop_front(); edata = q_data.pop_front();
        mcount--; nout++;
      end
      if (exp_ready && k < 4) begin
        q_rd.push_back(5'(10 + 2 * k)); q_data.push_back(64'h100 + 64'(k));
        q_rd.push_back(5'(11 + 2 * k)); q_data.push_back(64'h200 + 64'(k));
        mcount += 2; k++;
      end
      n_cmp++; if (RegWrite !== exp_we || pending !== 3'(mcount)) begin
        n_fail++; $display("FAIL bp_state_c%0d: got we=%0b p=%0d want we=%0b p=%0d", cyc, RegWrite, pending, exp_we, mcount);
      end
      if (exp_we) begin
        n_cmp++; if (RD !== erd || WriteData !== edata) begin
          n_fail++; $display("FAIL bp_data_c%0d: got rd=%0d wd=%h want rd=%0d wd=%h", cyc, RD, WriteData, erd, edata);
        end
      end
    end
    idle_inputs();
    n_cmp++; if (nout !== 8 || k !== 4) begin
      n_fail++; $display("FAIL bp_total: got writes=%0d pairs=%0d want writes=8 pairs=4", nout, k);
    end
    n_cmp++; if (saw_drop !== 1'b1) begin
      n_fail++; $display("FAIL bp_drop: got %0b want 1", saw_drop);
    end
  endtask

  task automatic test_mid_reset;
    ld_valid  = 1'b1; ld_rd  = 5'd20; ld_data  = 64'h20;
    alu_valid = 1'b1; alu_rd = 5'd21; alu_data = 64'h21;
    @(negedge clk);
    ld_rd  = 5'd22; ld_data  = 64'h22;
    alu_rd = 5'd23; alu_data = 64'h23;
    @(negedge clk);
    idle_inputs();
    n_cmp++; if (pending !== 3'd3) begin n_fail++; $display("FAIL mr_pending: got %0d want 3", pending); end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (RegWrite !== 1'b0 || pending !== 3'd0 || RD !== 5'd0 || WriteData !== 64'h0) begin
      n_fail++; $display("FAIL mr_reset: got we=%0b p=%0d rd=%0d wd=%h want all 0", RegWrite, pending, RD, WriteData);
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++; if (RegWrite !== 1'b0 || pending !== 3'd0) begin
        n_fail++; $display("FAIL mr_after%0d: got we=%0b p=%0d want we=0 p=0", i, RegWrite, pending);
      end
    end
  endtask

`ifdef WB_FORWARD_EN
  task automatic test_forward;
    ld_valid  = 1'b1; ld_rd  = 5'd7; ld_data  = 64'h1;
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 64'h2;
    @(negedge clk);
    idle_inputs();
    lookup_rs = 5'd7;
    #1;
    n_cmp++; if (lookup_hit !== 1'b1 || lookup_data !== 64'h2) begin
      n_fail++; $display("FAIL fwd_queue: got hit=%0b data=%h want hit=1 data=2", lookup_hit, lookup_data);
    end
    lookup_rs = 5'd0;
    #1;
    n_cmp++; if (lookup_hit !== 1'b0 || lookup_data !== 64'h0) begin
      n_fail++; $display("FAIL fwd_x0: got hit=%0b data=%h want hit=0 data=0", lookup_hit, lookup_data);
    end
    lookup_rs = 5'd7;
    @(negedge clk);
    n_cmp++; if (lookup_hit !== 1'b1 || lookup_data !== 64'h2) begin
      n_fail++; $display("FAIL fwd_prec: got hit=%0b data=%h want hit=1 data=2", lookup_hit, lookup_data);
    end
    @(negedge clk);
    n_cmp++; if (lookup_hit !== 1'b1 || lookup_data !== 64'h2) begin
      n_fail++; $display("FAIL fwd_outreg: got hit=%0b data=%h want hit=1 data=2", lookup_hit, lookup_data);
    end
    @(negedge clk);
    n_cmp++; if (lookup_hit !== 1'b0) begin
      n_fail++; $display("FAIL fwd_empty: got hit=%0b want 0", lookup_hit);
    end
    lookup_rs = 5'd0;
  endtask
`endif

  initial begin
    n_cmp  = 0;
    n_fail = 0;
`ifdef WB_FORWARD_EN
    lookup_rs = 5'd0;
`endif
    test_reset();
    test_single_push();
    test_dual_push();
    test_x0_filter();
    test_back_to_back();
    test_mid_reset();
`ifdef WB_FORWARD_EN
    test_forward();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of pending-write queue entries (power of two, at least 2).
REQ-002 SHALL have parameter XLEN, default 64, meaning the register data width.
REQ-003 Port clk, input, 1, the single clock; all state changes on posedge clk.
REQ-004 Port reset, input, 1, synchronous active-high reset.
REQ-005 Ports alu_valid (input, 1), alu_rd (input, 5), alu_data (input, XLEN): the ALU result write request.
REQ-006 Ports ld_valid (input, 1), ld_rd (input, 5), ld_data (input, XLEN): the load-unit result write request.
REQ-007 Port in_ready, output, 1, high when both sources may push this cycle.
REQ-008 Ports RegWrite (output, 1), RD (output, 5), WriteData (output, XLEN): the registered register-file write port.
REQ-009 Port pending, output, clog2(DEPTH)+1, the number of queued entries not yet presented on the write port.

Function
REQ-010 in_ready SHALL be 1 iff reset=0 and free entries >= 2; it is combinational from the current count only.
REQ-011 A request SHALL be accepted on a posedge where its valid=1 and in_ready=1; when in_ready=0, valid requests are ignored and sources hold valid/rd/data unchanged.
REQ-012 Accepted requests with rd=0 SHALL be discarded (not enqueued), with no effect on pending.
REQ-013 On simultaneous acceptance, the ld entry SHALL be enqueued ahead of the alu entry, and both SHALL be enqueued in the same cycle.
REQ-014 Each cycle the queue is non-empty, the head SHALL pop; RegWrite=1, RD=head rd, WriteData=head data are registered for exactly one cycle.
REQ-015 When the queue is empty, RegWrite SHALL be 0 next cycle; RD and WriteData hold their last values.
REQ-016 Latency: request accepted at edge N into an empty queue -> RegWrite=1 with that entry after edge N+1.
REQ-017 Push and pop in the same cycle SHALL both take effect; pending(next) = pending + pushes - pop.
REQ-018 Read/write pointers SHALL wrap modulo DEPTH; pending never exceeds DEPTH.
REQ-019 Writes SHALL leave in acceptance order; consecutive writes to the same rd both appear, the older first.

Reset
REQ-020 While reset=1 at a posedge: pointers=0, pending=0, RegWrite=0, RD=0, WriteData=0, and all requests are ignored.
REQ-021 Reset asserted while entries are pending SHALL discard them; no write issues after the reset edge.
REQ-022 The first request after reset deassertion SHALL be accepted on the first posedge with reset=0.

Configuration
REQ-023 Macro WB_FORWARD_EN, when defined, SHALL add the ports lookup_rs (input, 5), lookup_hit (output, 1) and lookup_data (output, XLEN).
REQ-024 With WB_FORWARD_EN, lookup_hit/lookup_data SHALL be combinational and return the youngest matching rd among queue entries and the current RegWrite=1 output.
REQ-025 With WB_FORWARD_EN, queue entries SHALL take precedence over the output register; lookup_rs=0 or no match gives lookup_hit=0 and lookup_data=0.
REQ-026 Without WB_FORWARD_EN, the lookup ports and search logic SHALL be absent, and all other behaviour is identical.

Verification
REQ-027 Single push: alu rd=5 data=0x1234 at edge N, queue empty -> after N+1 RegWrite=1 RD=5 WriteData=0x1234, and after N+2 RegWrite=0.
REQ-028 Dual push: ld rd=3 data=0xA and alu rd=3 data=0xB in the same cycle -> writes RD=3 0xA, then RD=3 0xB on consecutive cycles.
REQ-029 x0 filter: alu rd=0 data=0xFF accepted -> pending stays 0 and RegWrite never asserts.
REQ-030 Backpressure, DEPTH=4: 4 dual pushes on consecutive cycles -> in_ready drops once free < 2, and all accepted writes emerge in order with none lost or duplicated.
REQ-031 Mid-operation reset: 3 entries pending, reset pulsed for one cycle -> RegWrite=0, pending=0, and no stale write afterwards.
REQ-032 WB_FORWARD_EN: queue holds rd=7 0x1 then rd=7 0x2, lookup_rs=7 -> lookup_hit=1 with lookup_data=0x2; lookup_rs=0 -> lookup_hit=0.
